// File: rtl/rand_pool_pkg.sv
// Shared definitions for consumers of the 16-bit masking RNG stream.
// Holds the word width and the pool state encoding.
package rand_pool_pkg;

  localparam int RAND_W = 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_FILL   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } pool_state_t;

endpackage

// File: rtl/rand_fifo.sv
// Synchronous first-word-fall-through FIFO for RNG words.
// A flush empties it in one edge; push while full is accepted only alongside a pop.
module rand_fifo
  import rand_pool_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [RAND_W-1:0]          wr_data,
  output logic [RAND_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [RAND_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    full    = (level == LW'(DEPTH));
    do_pop  = pop && (level != '0);
    do_push = push && rst && !flush && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  // Storage is not reset; the level counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rand_pool.sv
// Consumer end of the masking RNG stream: warm-up discard, repetition-count health
// test and a buffered valid/ready read port that never exposes stale or failed words.
module rand_pool
  import rand_pool_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WARMUP     = 32,
  parameter int RCT_CUTOFF = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RAND_W-1:0]          rand_in,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [RAND_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       fail
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int WC_W  = $clog2(WARMUP+1);
  localparam int RC_W  = $clog2(RCT_CUTOFF+1);

  pool_state_t       state;
  logic [WC_W-1:0]   warm_cnt;
  logic [RAND_W-1:0] prev;
  logic              prev_valid;
  logic [RC_W-1:0]   rep_cnt;
  logic [RC_W-1:0]   rep_next;
  logic              trip;
  logic              pop;
  logic              push;
  logic              full;
  logic [RAND_W-1:0] head;

  // A tripping sample is never pushed, and the same edge flushes the buffer.
  always_comb begin
    rep_next = (prev_valid && (rand_in == prev)) ? rep_cnt + 1'b1 : RC_W'(1);
    trip     = (state != ST_FAIL) && (rep_next == RC_W'(RCT_CUTOFF));
    rd_valid = (state == ST_RUN) && (level != '0);
    pop      = rd_req && rd_valid;
    push     = ((state == ST_FILL) || (state == ST_RUN)) && !trip && (!full || pop);
    rd_data  = rd_valid ? head : '0;
    fail     = (state == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_WARMUP;
      warm_cnt   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      rep_cnt    <= '0;
    end else if (state != ST_FAIL) begin
      prev       <= rand_in;
      prev_valid <= 1'b1;
      rep_cnt    <= rep_next;
      if (trip) begin
        state <= ST_FAIL;
      end else begin
        case (state)
          ST_WARMUP: begin
            warm_cnt <= warm_cnt + 1'b1;
            if (warm_cnt == WC_W'(WARMUP - 1)) begin
              state <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (push && (level == LVL_W'(DEPTH - 1))) begin
              state <= ST_RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  rand_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (trip),
    .wr_data(rand_in),
    .head   (head),
    .level  (level),
    .full   (full)
  );

endmodule

// File: tb/tb_rand_pool.sv
// Self-checking bench for rand_pool: phase table with end-of-phase expectations,
// a behavioural queue model checked every cycle, and hand-written latency/order sequences.
module tb_rand_pool;

  localparam int DEPTH  = 8;
  localparam int WARMUP = 32;
  localparam int CUTOFF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rand_in;
  logic        rd_req;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  level;
  logic        fail;

  rand_pool #(
    .DEPTH     (DEPTH),
    .WARMUP    (WARMUP),
    .RCT_CUTOFF(CUTOFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rand_in (rand_in),
    .rd_req  (rd_req),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .level   (level),
    .fail    (fail)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef enum int {M_WARMUP, M_FILL, M_RUN, M_FAIL} mstate_t;
  mstate_t     m_state      = M_WARMUP;
  int          m_wcnt       = 0;
  logic [15:0] m_prev       = '0;
  bit          m_prev_valid = 1'b0;
  int          m_rep        = 0;
  logic [15:0] sb_q[$];
  logic [15:0] cnt          = '0;

  typedef struct {
    string name;
    bit    rst;
    int    mode;
    int    cycles;
    bit    req;
    int    exp_level;
    bit    exp_valid;
    bit    exp_fail;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  function automatic bit mValid();
    return (m_state == M_RUN) && (sb_q.size() != 0);
  endfunction

  // Reference behaviour of one clock edge, written against the queue scoreboard.
  task automatic modelEdge(input logic r, input logic [15:0] d);
    int rn;
    if (!r) begin
      m_state      = M_WARMUP;
      m_wcnt       = 0;
      m_prev_valid = 1'b0;
      m_rep        = 0;
      sb_q.delete();
    end else if (m_state != M_FAIL) begin
      rn           = (m_prev_valid && d == m_prev) ? m_rep + 1 : 1;
      m_prev       = d;
      m_prev_valid = 1'b1;
      m_rep        = rn;
      if (rn == CUTOFF) begin
        m_state = M_FAIL;
        sb_q.delete();
      end else if (m_state == M_WARMUP) begin
        m_wcnt++;
        if (m_wcnt == WARMUP) m_state = M_FILL;
      end else begin
        if (sb_q.size() < DEPTH) sb_q.push_back(d);
        if (m_state == M_FILL && sb_q.size() == DEPTH) m_state = M_RUN;
      end
    end
  endtask

  task automatic checkOutput();
    bit ev;
    ev = mValid();
    check("rd_valid", rd_valid, ev);
    if (ev) check("rd_data", rd_data, sb_q[0]);
    else    check("rd_data_gated", rd_data, 0);
    check("level", level, sb_q.size());
    check("fail", fail, m_state == M_FAIL);
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] d, input logic req);
    rst     = r;
    rand_in = d;
    rd_req  = req;
    #1;
    if (r && req && mValid()) begin
      check("pop_data", rd_data, sb_q[0]);
      sb_q.delete(0);
    end
    @(posedge clk);
    modelEdge(r, d);
    #1;
    checkOutput();
  endtask

  function automatic logic [15:0] genData(input int mode);
    case (mode)
      0:       return cnt;
      1:       return 16'hA5A5;
      2:       return 16'h5A5A;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic runCycles(input logic r, input int mode, input int n, input logic req);
    for (int c = 0; c < n; c++) begin
      applyStimulus(r, genData(mode), req);
      if (mode == 0) cnt++;
    end
  endtask

  initial begin
    rst     = 1'b0;
    rand_in = '0;
    rd_req  = 1'b0;

    // mode: 0 counter, 1 A5A5, 2 5A5A, 3 random
    vecs.push_back('{"reset",          0, 0,  2, 0, 0, 0, 0});
    vecs.push_back('{"fill_edge39",    1, 0, 39, 0, 7, 0, 0});
    vecs.push_back('{"fill_edge40",    1, 0,  1, 0, 8, 1, 0});
    vecs.push_back('{"stream20",       1, 0, 20, 1, 8, 1, 0});
    vecs.push_back('{"idle50",         1, 0, 50, 0, 8, 1, 0});
    vecs.push_back('{"rct_trip",       1, 1,  4, 0, 0, 0, 1});
    vecs.push_back('{"fail_sticky",    1, 3, 10, 1, 0, 0, 1});
    vecs.push_back('{"reset2",         0, 0,  1, 0, 0, 0, 0});
    vecs.push_back('{"refill",         1, 0, 40, 0, 8, 1, 0});
    vecs.push_back('{"rep3_run",       1, 1,  3, 0, 8, 1, 0});
    vecs.push_back('{"break_run",      1, 2,  1, 0, 8, 1, 0});
    vecs.push_back('{"reset3",         0, 0,  1, 0, 0, 0, 0});
    vecs.push_back('{"rep3_warm",      1, 1,  3, 0, 0, 0, 0});
    vecs.push_back('{"break_warm",     1, 2,  1, 0, 0, 0, 0});
    vecs.push_back('{"warm_rest",      1, 0, 20, 0, 0, 0, 0});
    vecs.push_back('{"warm_fill",      1, 0, 16, 0, 8, 1, 0});
    vecs.push_back('{"reset4",         0, 0,  1, 0, 0, 0, 0});
    vecs.push_back('{"fill_lvl5",      1, 0, 37, 0, 5, 0, 0});
    vecs.push_back('{"reset_in_fill",  0, 0,  1, 0, 0, 0, 0});
    vecs.push_back('{"req_ignored",    1, 0, 39, 1, 7, 0, 0});
    vecs.push_back('{"req_first",      1, 0,  1, 1, 8, 1, 0});
    vecs.push_back('{"stream10",       1, 0, 10, 1, 8, 1, 0});
    vecs.push_back('{"reset_in_run",   0, 0,  1, 1, 0, 0, 0});
    vecs.push_back('{"relatch39",      1, 0, 39, 0, 7, 0, 0});
    vecs.push_back('{"relatch40",      1, 0,  1, 0, 8, 1, 0});

    foreach (vecs[i]) begin
      runCycles(vecs[i].rst, vecs[i].mode, vecs[i].cycles, vecs[i].req);
      check({vecs[i].name, ".level"}, level, vecs[i].exp_level);
      check({vecs[i].name, ".rd_valid"}, rd_valid, vecs[i].exp_valid);
      check({vecs[i].name, ".fail"}, fail, vecs[i].exp_fail);
    end

    // First word after release is the sample of edge WARMUP+1; a full pool keeps edges 33..40.
    runCycles(1'b0, 0, 1, 1'b0);
    cnt = '0;
    runCycles(1'b1, 0, 39, 1'b0);
    check("latency.not_yet", rd_valid, 0);
    runCycles(1'b1, 0, 1, 1'b0);
    check("latency.valid", rd_valid, 1);
    check("latency.first_word", rd_data, 16'd32);
    runCycles(1'b1, 0, 50, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      check("held_word", rd_data, 16'(32 + k));
      runCycles(1'b1, 0, 1, 1'b1);
    end

    // Irregular consumer in RUN; the scoreboard tracks every pop.
    for (int k = 0; k < 30; k++) begin
      runCycles(1'b1, 0, 1, 1'($urandom_range(0, 1)));
    end
    check("random_req.level", level, DEPTH);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
